// File: rtl/dlfloat_pkg.sv
// Shared dlfloat16 constants, sequencer state encoding and the packed operand pair.
package dlfloat_pkg;

  localparam int unsigned DLF_W    = 16;
  localparam logic [15:0] DLF_NAN  = 16'hFFFF;
  localparam logic [15:0] DLF_ZERO = 16'h0000;
  localparam int unsigned DLF_BIAS = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [DLF_W-1:0] a;
    logic [DLF_W-1:0] b;
  } dlf_pair_t;

endpackage

// File: rtl/dlfloat_operand_sequencer_if.sv
// Operand input stream and MAC issue stream of the dlfloat operand sequencer.
interface dlfloat_operand_sequencer_if
  import dlfloat_pkg::*;
();

  logic [DLF_W-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic [DLF_W-1:0] a_out;
  logic [DLF_W-1:0] b_out;
  logic             op_valid;
  logic             op_ready;
  logic             acc_clear;
  logic             last;

  // Upstream word source plus MAC consumer.
  modport master (
    output data_in, in_valid, op_ready,
    input  in_ready, a_out, b_out, op_valid, acc_clear, last
  );

  // The sequencer itself.
  modport slave (
    input  data_in, in_valid, op_ready,
    output in_ready, a_out, b_out, op_valid, acc_clear, last
  );

endinterface

// File: rtl/dlfloat_pair_fifo.sv
// Operand-pair FIFO with wrap-bit pointers; exposes post-update flags and head so the
// owner can register its outputs without an extra cycle of latency.
module dlfloat_pair_fifo
  import dlfloat_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  dlf_pair_t wdata_i,
  output logic      full_nxt_o,
  output logic      empty_nxt_o,
  output dlf_pair_t head_nxt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  dlf_pair_t     mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + (AW+1)'(push_i);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop_i);
    empty_nxt_o = (wr_ptr_d == rd_ptr_d);
    full_nxt_o  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    // The word being written this cycle becomes the head when it lands on the next read slot.
    if (push_i && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) head_nxt_o = wdata_i;
    else                                                   head_nxt_o = mem_q[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dlfloat_operand_sequencer.sv
// Pairs a serial A/B dlfloat16 word stream and issues one pair per cycle to the MAC.
// Optional DLF_SPECIAL_DETECT_EN adds a sticky nan_seen flag for pushed 16'hFFFF operands.
module dlfloat_operand_sequencer
  import dlfloat_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  dlfloat_operand_sequencer_if.slave bus,
  output logic                 busy,
  output logic                 done
`ifdef DLF_SPECIAL_DETECT_EN
  ,output logic                nan_seen
`endif
);

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic             phase_q, phase_d;
  logic [DLF_W-1:0] a_hold_q, a_hold_d, a_out_q, a_out_d, b_out_q, b_out_d;
  logic             in_ready_q, in_ready_d, op_valid_q, op_valid_d;
  logic             acc_clear_q, acc_clear_d, last_q, last_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             accept, push, pop;
  logic             full_nxt, empty_nxt;
  dlf_pair_t        wdata, head_nxt;

  assign accept = (state_q == RUN) && bus.in_valid && in_ready_q;
  assign push   = accept && phase_q;
  assign pop    = op_valid_q && bus.op_ready;
  assign wdata  = '{a: a_hold_q, b: bus.data_in};

  dlfloat_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    (wdata),
    .full_nxt_o (full_nxt),
    .empty_nxt_o(empty_nxt),
    .head_nxt_o (head_nxt)
  );

  // Next-state and next-output logic; outputs are derived from next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q + LEN_W'(pop);
    phase_d   = phase_q;
    a_hold_d  = a_hold_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = cfg_len;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          phase_d   = 1'b0;
          state_d   = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (!phase_q) begin
            a_hold_d = bus.data_in;
            phase_d  = 1'b1;
          end else begin
            in_cnt_d = in_cnt_q + LEN_W'(1);
            phase_d  = 1'b0;
          end
        end
        if (in_cnt_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if ((out_cnt_d == len_q) && empty_nxt) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_q == DONE);
    in_ready_d  = (state_d == RUN) && !full_nxt && (in_cnt_d < len_d);
    op_valid_d  = ((state_d == RUN) || (state_d == DRAIN)) && !empty_nxt;
    a_out_d     = op_valid_d ? head_nxt.a : DLF_ZERO;
    b_out_d     = op_valid_d ? head_nxt.b : DLF_ZERO;
    acc_clear_d = op_valid_d && (out_cnt_d == '0);
    last_d      = op_valid_d && (out_cnt_d == (len_d - LEN_W'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      phase_q     <= 1'b0;
      a_hold_q    <= DLF_ZERO;
      in_ready_q  <= 1'b0;
      op_valid_q  <= 1'b0;
      a_out_q     <= DLF_ZERO;
      b_out_q     <= DLF_ZERO;
      acc_clear_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      phase_q     <= phase_d;
      a_hold_q    <= a_hold_d;
      in_ready_q  <= in_ready_d;
      op_valid_q  <= op_valid_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      acc_clear_q <= acc_clear_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.a_out     = a_out_q;
  assign bus.b_out     = b_out_q;
  assign bus.acc_clear = acc_clear_q;
  assign bus.last      = last_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef DLF_SPECIAL_DETECT_EN
  logic nan_q, nan_d;

  // Sticky until the next accepted start; operands themselves pass through untouched.
  always_comb begin
    nan_d = nan_q;
    if ((state_q == IDLE) && start)                                      nan_d = 1'b0;
    else if (push && ((a_hold_q == DLF_NAN) || (bus.data_in == DLF_NAN))) nan_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nan_q <= 1'b0;
    else        nan_q <= nan_d;
  end

  assign nan_seen = nan_q;
`endif

endmodule

// File: tb/tb_dlfloat_operand_sequencer.sv
// Self-checking bench for dlfloat_operand_sequencer: directed vectors plus randomized
// handshakes, checked against a pair-level queue model. Set DLF_SPECIAL_DETECT_EN to cover nan_seen.
module tb_dlfloat_operand_sequencer;
  import dlfloat_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_len = '0;
  logic       busy, done;
`ifdef DLF_SPECIAL_DETECT_EN
  logic       nan_seen;
`endif

  dlfloat_operand_sequencer_if bus();

  dlfloat_operand_sequencer #(.DEPTH(4), .LEN_W(8)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cfg_len(cfg_len),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
`ifdef DLF_SPECIAL_DETECT_EN
    ,.nan_seen(nan_seen)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] words[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_rdy"},   32'(bus.in_ready), 32'd0);
    chk({tag, "_opv"},   32'(bus.op_valid), 32'd0);
    chk({tag, "_a"},     32'(bus.a_out), 32'd0);
    chk({tag, "_b"},     32'(bus.b_out), 32'd0);
    chk({tag, "_clr"},   32'(bus.acc_clear), 32'd0);
    chk({tag, "_last"},  32'(bus.last), 32'd0);
  endtask

  function automatic logic [15:0] rnd_word();
    return 16'($urandom_range(0, 32'hFFFE));
  endfunction

  // Runs one vector from IDLE using words[]; pair i is expected as (words[2i], words[2i+1]).
  task automatic run_vec(input int len, input int vprob, input int rprob, input int hold,
                         input int exp_fill, input bit noise);
    int          widx = 0;
    int          pidx = 0;
    bit          fin = 0;
    bit          pv = 0;
    bit          nan_exp = 0;
    bit          nan_next = 0;
    logic [15:0] pa = '0, pb = '0;
    start = 1'b1;
    cfg_len = 8'(len);
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      start = 1'b0;
      if (!bus.op_valid) begin
        chk("a_zero_idle", 32'(bus.a_out), 32'd0);
        chk("b_zero_idle", 32'(bus.b_out), 32'd0);
      end
      if (pv) begin
        chk("stall_valid", 32'(bus.op_valid), 32'd1);
        chk("stall_a", 32'(bus.a_out), 32'(pa));
        chk("stall_b", 32'(bus.b_out), 32'(pb));
      end
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
`ifdef DLF_SPECIAL_DETECT_EN
      chk("nan_seen", 32'(nan_seen), 32'(nan_exp));
`endif
      if (exp_fill >= 0 && cyc == hold) begin
        chk("fill_words", 32'(widx), 32'(exp_fill));
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = (widx < 2*len) && ($urandom_range(99) < 32'(vprob));
      if (widx < 2*len) bus.data_in = words[widx];
      else              bus.data_in = rnd_word();
      bus.op_ready = (cyc >= hold) && ($urandom_range(99) < 32'(rprob));
      if (noise && $urandom_range(3) == 0) begin
        start = 1'b1;
        cfg_len = 8'($urandom);
      end
      if (bus.in_valid && bus.in_ready) begin
        if ((widx % 2) == 1 && (words[widx-1] == DLF_NAN || words[widx] == DLF_NAN)) nan_next = 1;
        widx++;
      end
      if (bus.op_valid && bus.op_ready) begin
        if (pidx < len) begin
          chk("pair_a", 32'(bus.a_out), 32'(words[2*pidx]));
          chk("pair_b", 32'(bus.b_out), 32'(words[2*pidx+1]));
          chk("acc_clear", 32'(bus.acc_clear), 32'(pidx == 0));
          chk("last", 32'(bus.last), 32'(pidx == len-1));
        end else begin
          chk("extra_pair", 32'(pidx), 32'(len - 1));
        end
        pidx++;
        pv = 0;
      end else begin
        pv = bus.op_valid;
        pa = bus.a_out;
        pb = bus.b_out;
      end
      step();
      nan_exp = nan_next;
      if (done) fin = 1;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_ready = 1'b0;
    chk("timeout", 32'(fin), 32'd1);
    chk("pairs_out", 32'(pidx), 32'(len));
    chk("words_in", 32'(widx), 32'(2*len));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("opv_at_done", 32'(bus.op_valid), 32'd0);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
`ifdef DLF_SPECIAL_DETECT_EN
    chk("nan_sticky", 32'(nan_seen), 32'(nan_exp));
`endif
  endtask

  task automatic fill_random(input int len);
    words = {};
    for (int i = 0; i < 2*len; i++) words.push_back(rnd_word());
  endtask

  initial begin
    bus.data_in  = '0;
    bus.in_valid = 1'b0;
    bus.op_ready = 1'b0;
    repeat (3) step();
    chk_quiet("reset");
    rst_n = 1'b1;
    step();
    chk_quiet("post_reset");

    // Single pair: acc_clear and last coincide.
    words = {16'h3E00, 16'h4000};
    run_vec(1, 100, 100, 0, -1, 0);

    // Zero length goes straight to DONE; no pair may ever appear.
    words = {};
    run_vec(0, 100, 100, 0, -1, 0);

    // MAC stalled: FIFO fills with 4 pairs (8 words) and in_ready drops, then drains in order.
    fill_random(6);
    run_vec(6, 100, 100, 20, 8, 0);

    // Continuous input, random MAC stalls, 20 pairs.
    fill_random(20);
    run_vec(20, 100, 50, 0, -1, 0);

    // Reset after 3 accepted words of a 4-pair vector.
    start = 1'b1;
    cfg_len = 8'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.data_in = rnd_word();
      step();
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_quiet("mid_reset");
    step();
    rst_n = 1'b1;
    step();
    chk_quiet("after_mid_reset");
    fill_random(3);
    run_vec(3, 100, 100, 0, -1, 0);

`ifdef DLF_SPECIAL_DETECT_EN
    // NaN in B of pair 2, then a clean vector whose start must clear the flag.
    fill_random(4);
    words[5] = DLF_NAN;
    run_vec(4, 100, 70, 0, -1, 0);
    fill_random(2);
    run_vec(2, 100, 100, 0, -1, 0);
`endif

    // Random vectors with random handshakes and start asserted while busy.
    for (int v = 0; v < 8; v++) begin
      int len;
      len = int'($urandom_range(1, 12));
      fill_random(len);
      run_vec(len, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, -1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
